btn_merge_debounce: RTL and testbench

Parametrised successor to the wired/wireless button merger. It merges N_BTN wired and N_BTN wireless button lines under a runtime source-select. Each merged line is synchronised and debounced through a per-channel state machine, and the block emits clean levels, one-cycle press/release pulses and optional auto-repeat pulses. It sits between the board/wireless-receiver inputs and the game control FSMs.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_channel.sv | 124 ++++++++++++
 rtl/btn_merge_debounce.sv | 55 +++++
 tb/tb_btn_merge_debounce.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the button merge/debounce block.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_t;

  localparam logic [1:0] SRC_BOTH     = 2'b00;
  localparam logic [1:0] SRC_WIRED    = 2'b01;
  localparam logic [1:0] SRC_WIRELESS = 2'b10;
  localparam logic [1:0] SRC_LOCK     = 2'b11;

  // Width of a counter holding values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and optional auto-repeat.
// Auto-repeat is present only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES    = 250000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rep
);

  localparam int DB_W = cnt_w(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync;
  logic            s;
  btn_state_t      state;
  logic [DB_W-1:0] db_cnt;
  logic            accept_press;

  assign s = sync[1];
  assign accept_press = (state == DB_PRESS) && s && (db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= 2'b00;
      state  <= IDLE;
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state  <= DB_PRESS;
            db_cnt <= DB_W'(1);
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state  <= HELD;
            db_cnt <= '0;
            level  <= 1'b1;
            press  <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state  <= DB_RELEASE;
            db_cnt <= DB_W'(1);
          end
        end
        DB_RELEASE: begin
          // A short dip returns to HELD silently; the level never dropped.
          if (s) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state  <= IDLE;
            db_cnt <= '0;
            level  <= 1'b0;
            rel    <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = cnt_w(REPEAT_DELAY + REPEAT_RATE);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_DELAY + REPEAT_RATE - 1);

  logic [RPT_W-1:0] rpt_cnt;

  // Counts only HELD->HELD cycles, so dips in DB_RELEASE pause the cadence.
  // Past the first pulse the counter cycles within DELAY..DELAY+RATE-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt <= '0;
      rep     <= 1'b0;
    end else begin
      rep <= 1'b0;
      if (accept_press) begin
        rpt_cnt <= '0;
      end else if (state == HELD && s) begin
        if (rpt_cnt == RPT_LAST) begin
          rpt_cnt <= RPT_DELAY;
          rep     <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + RPT_W'(1);
          if (rpt_cnt == RPT_FIRST) rep <= 1'b1;
        end
      end
    end
  end
`else
  assign rep = 1'b0;
`endif

endmodule

// File: rtl/btn_merge_debounce.sv
// Merges wired/wireless buttons per src_sel and debounces each channel.
// Define BTN_AUTOREPEAT_EN to enable the auto-repeat pulse outputs.
module btn_merge_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN        = 8,
  parameter int DB_CYCLES    = 250000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] bt_wired,
  input  logic [N_BTN-1:0] bt_wireless,
  input  logic [1:0]       src_sel,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_active
);

  logic [N_BTN-1:0] merged;

  // src_sel is unsynchronised; the per-channel debounce absorbs its changes.
  always_comb begin
    merged = '0;
    case (src_sel)
      SRC_BOTH:     merged = bt_wired | bt_wireless;
      SRC_WIRED:    merged = bt_wired;
      SRC_WIRELESS: merged = bt_wireless;
      SRC_LOCK:     merged = '0;
      default:      merged = '0;
    endcase
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (merged[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .rep  (btn_repeat[i])
    );
  end

  assign any_active = |btn_level;

endmodule

// File: tb/tb_btn_merge_debounce.sv
// Directed bench for btn_merge_debounce with a run-length behavioural model.
module tb_btn_merge_debounce;

  localparam int N     = 4;
  localparam int DB    = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] bt_wired = '0;
  logic [N-1:0] bt_wireless = '0;
  logic [1:0]   src_sel = 2'b00;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic         any_active;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  btn_merge_debounce #(
    .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .rst(rst), .bt_wired(bt_wired), .bt_wireless(bt_wireless),
    .src_sel(src_sel), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat), .any_active(any_active)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- behavioural model ----------------
  // Level flips once DB consecutive synchronised samples disagree with it.
  // Samples reach the debouncer two cycles after the raw input changes.
  bit           d1[N], d2[N], lvl[N], prev_s[N];
  int           run[N], held[N];
  logic [N-1:0] m_level = '0, m_press = '0, m_rel = '0, m_rep = '0;

  function automatic logic [N-1:0] merge(input logic [1:0] sel,
                                          input logic [N-1:0] w,
                                          input logic [N-1:0] wl);
    if (sel == 2'b00) return w | wl;
    if (sel == 2'b01) return w;
    if (sel == 2'b10) return wl;
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] mg;
    mg = merge(src_sel, bt_wired, bt_wireless);
    for (int i = 0; i < N; i++) begin
      bit smp, nl;
      if (rst) begin
        d1[i] = 0; d2[i] = 0; lvl[i] = 0; prev_s[i] = 0;
        run[i] = 0; held[i] = 0;
        m_level[i] = 0; m_press[i] = 0; m_rel[i] = 0; m_rep[i] = 0;
      end else begin
        smp = d2[i];
        d2[i] = d1[i];
        d1[i] = mg[i];
        nl = lvl[i];
        run[i] = (smp != lvl[i]) ? run[i] + 1 : 0;
        if (run[i] == DB) begin
          nl = !lvl[i];
          run[i] = 0;
        end
        m_press[i] = nl && !lvl[i];
        m_rel[i]   = !nl && lvl[i];
        m_rep[i]   = 1'b0;
        if (m_press[i]) begin
          held[i] = 0;
        end else if (lvl[i] && nl && smp && prev_s[i]) begin
          held[i]++;
          m_rep[i] = RPT_ON && (held[i] >= DELAY) && ((held[i] - DELAY) % RATE == 0);
        end
        lvl[i] = nl;
        prev_s[i] = smp;
        m_level[i] = nl;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("model_level",   btn_level,   m_level);
      check("model_press",   btn_press,   m_press);
      check("model_release", btn_release, m_rel);
      check("model_repeat",  btn_repeat,  m_rep);
      check("model_any",     {{(N-1){1'b0}}, any_active}, {{(N-1){1'b0}}, |m_level});
    end
  end

  // ---------------- driver ----------------
  task automatic wait_until(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    // reset state
    wait_until(2);
    check("reset_level", btn_level, 4'b0000);
    check("reset_pulses", btn_press | btn_release | btn_repeat, 4'b0000);
    rst = 1'b0;

    // clean press and release on wired[0]
    wait_until(10); bt_wired[0] = 1'b1;
    wait_until(15); check("press0_early", btn_press, 4'b0000);
    wait_until(16); check("press0", btn_press, 4'b0001);
    check("level0", btn_level, 4'b0001);
    wait_until(17); check("press0_one_cycle", btn_press, 4'b0000);
    wait_until(20); bt_wired[0] = 1'b0;
    wait_until(25); check("level0_hold", btn_level, 4'b0001);
    wait_until(26); check("release0", btn_release, 4'b0001);
    check("level0_off", btn_level, 4'b0000);

    // 3-cycle bounce on wireless[1]
    wait_until(35); bt_wireless[1] = 1'b1;
    wait_until(38); bt_wireless[1] = 1'b0;
    wait_until(50); check("bounce1_level", btn_level, 4'b0000);

    // source select: wireless ignored in wired-only mode
    wait_until(55); src_sel = 2'b01; bt_wireless[2] = 1'b1;
    wait_until(65); check("wired_only_level2", btn_level, 4'b0000);
    src_sel = 2'b10;
    wait_until(71); check("wireless_press2", btn_press, 4'b0100);
    wait_until(75); bt_wireless[2] = 1'b0; src_sel = 2'b00;

    // auto-repeat on wired[3], with a 2-cycle release glitch
    wait_until(90); bt_wired[3] = 1'b1;
    wait_until(96);  check("press3", btn_press, 4'b1000);
    wait_until(106); check("repeat3_first", btn_repeat, RPT_ON ? 4'b1000 : 4'b0000);
    wait_until(107); check("repeat3_gap", btn_repeat, 4'b0000);
    wait_until(109); check("repeat3_second", btn_repeat, RPT_ON ? 4'b1000 : 4'b0000);
    wait_until(112); check("repeat3_third", btn_repeat, RPT_ON ? 4'b1000 : 4'b0000);
    wait_until(113); bt_wired[3] = 1'b0;
    wait_until(115); bt_wired[3] = 1'b1;
    check("repeat3_pre_glitch", btn_repeat, RPT_ON ? 4'b1000 : 4'b0000);
    wait_until(118); check("repeat3_paused", btn_repeat, 4'b0000);
    check("glitch_level3", btn_level, 4'b1000);
    wait_until(121); check("repeat3_shifted", btn_repeat, RPT_ON ? 4'b1000 : 4'b0000);
    wait_until(125); bt_wired[3] = 1'b0;
    wait_until(131); check("release3", btn_release, 4'b1000);

    // lockout releases every held channel together
    wait_until(140); bt_wired = 4'b1111;
    wait_until(146); check("press_all", btn_press, 4'b1111);
    wait_until(160); src_sel = 2'b11;
    wait_until(165); check("lock_any_before", {3'b000, any_active}, 4'b0001);
    wait_until(166); check("lock_release_all", btn_release, 4'b1111);
    check("lock_any_after", {3'b000, any_active}, 4'b0000);

    // reset while channel 0 is held
    wait_until(175); src_sel = 2'b01; bt_wired = 4'b0001;
    wait_until(185); check("held0_before_rst", btn_level, 4'b0001);
    wait_until(190); rst = 1'b1;
    wait_until(191); check("rst_level", btn_level, 4'b0000);
    check("rst_no_release", btn_release, 4'b0000);
    rst = 1'b0;
    wait_until(196); check("repress0_early", btn_level, 4'b0000);
    wait_until(197); check("repress0", btn_press, 4'b0001);
    wait_until(205); bt_wired = 4'b0000;
    wait_until(215);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
